imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter IMEM_AW, default 16, giving the byte-address bits decoded by the instruction memory (64 KiB = 16k words).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port f_req_i, input, 1, fetch-port read request.
REQ-005 SHALL have port f_addr_i, input, 32, fetch byte address.
REQ-006 SHALL have port f_gnt_o, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have ports f_rvalid_o, output, 1; f_rdata_o, output, 32; f_err_o, output, 1, carrying the fetch response.
REQ-008 SHALL have port f_rready_i, input, 1, fetch consumer accepts the response.
REQ-009 SHALL have ports d_req_i, d_addr_i, d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o and d_rready_i, identical in width and meaning to the fetch ports, for the debug/loader read port.
REQ-010 SHALL have port mem_rden_o, output, 1, driving the memory read enable.
REQ-011 SHALL have port mem_addr_o, output, 32, driving the memory byte address.
REQ-012 SHALL have port mem_data_i, input, 32, the synchronous-read memory data, valid one cycle after a rden cycle and held while rden is low.

Function
REQ-013 SHALL keep at most one response outstanding in a response register {rsp_valid, rsp_owner (F/D), rsp_err}.
REQ-014 SHALL treat the slot as free when rsp_valid=0, or when rsp_valid=1 and the owner's rready is high in the same cycle (back-to-back throughput of 1 read/cycle).
REQ-015 SHALL grant at most one requester per cycle, only when the slot is free; gnt is combinational from req and slot state.
REQ-016 SHALL grant with fixed priority when RR is compiled out: fetch wins over debug.
REQ-017 SHALL classify a granted address as an error if addr[1:0]!=0 or any addr[31:IMEM_AW] bit is set.
REQ-018 SHALL, for a non-error grant, assert mem_rden_o=1 and mem_addr_o=granted address in the grant cycle, then set rsp_valid=1, rsp_err=0 and the owner on the next edge.
REQ-019 SHALL, for an error grant, keep mem_rden_o=0, then set rsp_valid=1 and rsp_err=1 on the next edge; the response data is 0x00000000.
REQ-020 SHALL route the response only to the owner: owner rvalid=rsp_valid, rdata=mem_data_i (0 if rsp_err), err=rsp_err; the non-owner sees rvalid=0, rdata=0, err=0.
REQ-021 SHALL hold mem_rden_o=0 while a response is stalled (owner rready=0), so mem_data_i stays stable; the response is held unchanged until accepted.
REQ-022 SHALL clear rsp_valid on acceptance when no new grant occurs that cycle.
REQ-023 SHALL drive mem_addr_o=0 whenever mem_rden_o=0.
REQ-024 SHALL allow the requester to drop req without a grant; no state changes in that case.

Reset
REQ-025 SHALL, while rst_ni=0, force rsp_valid=0, rsp_err=0, rsp_owner=F and the RR pointer to F; all gnt/rvalid/err/rden outputs 0, all data/addr outputs 0.
REQ-026 SHALL discard any outstanding response on reset mid-operation; no response is delivered after reset deasserts for a read granted before it.

Configuration
REQ-027 SHALL honour macro IMEM_ARB_RR_EN: when defined, if both request in the same cycle, the port not granted last wins; a pointer toggles to the other port after each contended grant; uncontended grants follow the requester and do not move the pointer.
REQ-028 SHALL, when IMEM_ARB_RR_EN is undefined, use fixed priority per REQ-016 and implement no pointer state.

Verification
REQ-029 SHALL cover: f_req=1 addr 0x00000010 with rready held 1 -> f_gnt same cycle, mem_rden=1, mem_addr=0x10; next cycle f_rvalid=1, f_rdata=mem[4], f_err=0.
REQ-030 SHALL cover: f_req and d_req both 1 for 4 cycles, rready=1 -> fixed: 4 fetch grants, d_gnt=0; with IMEM_ARB_RR_EN: grants F,D,F,D.
REQ-031 SHALL cover: d_req addr 0x00000003, then addr 0x00010000 -> both grant, mem_rden=0, d_rvalid=1 with d_err=1 and d_rdata=0.
REQ-032 SHALL cover: fetch granted, f_rready=0 for 3 cycles -> f_rvalid and f_rdata stable, mem_rden=0, no grants; rready=1 -> accepted, a new grant is allowed in the same cycle.
REQ-033 SHALL cover: rst_ni pulled low the cycle after a grant -> all outputs 0 immediately; after release, no rvalid until a new grant.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) read arbiter onto a sync-read instruction memory; IMEM_ARB_RR_EN selects round-robin, else fetch wins.
// Latency: grant and memory read in the same cycle, response one cycle later; one read per cycle when responses drain.
// Backpressure: a single response slot holds until its owner's rready; no grants and mem_rden_o=0 while it stalls.
module imem_arbiter #(
  parameter int IMEM_AW = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  output logic [31:0] f_rdata_o,
  output logic        f_err_o,
  input  logic        f_rready_i,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        d_rready_i,
  output logic        mem_rden_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  logic        rsp_vld;
  logic        rsp_err;
  owner_e      rsp_owner;
  logic        owner_rdy;
  logic        slot_free;
  logic        sel_d;
  logic        gnt_any;
  logic [31:0] gnt_addr;
  logic        addr_err;

  assign owner_rdy = (rsp_owner == OWN_D) ? d_rready_i : f_rready_i;
  assign slot_free = !rsp_vld || owner_rdy;

`ifdef IMEM_ARB_RR_EN
  owner_e rr_ptr;
  logic   contended;

  assign contended = f_req_i && d_req_i;
  assign sel_d     = contended ? (rr_ptr == OWN_D) : d_req_i;

  // Pointer names the port that wins the next contended grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= OWN_F;
    end else if (gnt_any && contended) begin
      rr_ptr <= (rr_ptr == OWN_F) ? OWN_D : OWN_F;
    end
  end
`else
  assign sel_d = !f_req_i && d_req_i;
`endif

  // Grant is qualified with reset so outputs are quiet while rst_ni is low.
  assign gnt_any  = rst_ni && slot_free && (f_req_i || d_req_i);
  assign f_gnt_o  = gnt_any && !sel_d;
  assign d_gnt_o  = gnt_any && sel_d;
  assign gnt_addr = sel_d ? d_addr_i : f_addr_i;
  assign addr_err = (gnt_addr[1:0] != 2'b00) || ((gnt_addr >> IMEM_AW) != 32'h0);

  assign mem_rden_o = gnt_any && !addr_err;
  assign mem_addr_o = mem_rden_o ? gnt_addr : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_owner <= OWN_F;
    end else if (gnt_any) begin
      rsp_vld   <= 1'b1;
      rsp_err   <= addr_err;
      rsp_owner <= sel_d ? OWN_D : OWN_F;
    end else if (rsp_vld && owner_rdy) begin
      rsp_vld   <= 1'b0;
    end
  end

  // Memory data stays valid during a stall because no new read is issued.
  assign f_rvalid_o = rsp_vld && (rsp_owner == OWN_F);
  assign d_rvalid_o = rsp_vld && (rsp_owner == OWN_D);
  assign f_err_o    = f_rvalid_o && rsp_err;
  assign d_err_o    = d_rvalid_o && rsp_err;
  assign f_rdata_o  = (f_rvalid_o && !rsp_err) ? mem_data_i : 32'h0;
  assign d_rdata_o  = (d_rvalid_o && !rsp_err) ? mem_data_i : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_imem_arbiter;

  localparam int AW   = 16;
  localparam int MEMW = 1 << (AW - 2);

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        f_req_i = 1'b0, d_req_i = 1'b0;
  logic [31:0] f_addr_i = '0, d_addr_i = '0;
  logic        f_rready_i = 1'b1, d_rready_i = 1'b1;
  logic        f_gnt_o, d_gnt_o, f_rvalid_o, d_rvalid_o, f_err_o, d_err_o, mem_rden_o;
  logic [31:0] f_rdata_o, d_rdata_o, mem_addr_o;
  logic [31:0] mem_q = '0;
  logic [31:0] mem [0:MEMW-1];

  int n_checks = 0;
  int n_errors = 0;

  imem_arbiter #(.IMEM_AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .f_rdata_o(f_rdata_o), .f_err_o(f_err_o), .f_rready_i(f_rready_i),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o), .d_rready_i(d_rready_i),
    .mem_rden_o(mem_rden_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_q)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read memory: data appears the cycle after rden and holds otherwise.
  always @(posedge clk_i) if (mem_rden_o) mem_q <= mem[mem_addr_o[AW-1:2]];

  // Reference model: one outstanding read described by owner, error flag and address.
  logic        m_valid = 1'b0, m_owner = 1'b0, m_err = 1'b0, m_ptr = 1'b0;
  logic [31:0] m_addr = '0;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({32'h0, a} >= (64'd1 << AW));
  endfunction

  // 0 = nobody granted, 1 = fetch, 2 = debug
  function automatic int winner();
    logic free;
    free = !m_valid || (m_owner ? d_rready_i : f_rready_i);
    if (!rst_ni || !free) return 0;
    if (f_req_i && d_req_i) begin
`ifdef IMEM_ARB_RR_EN
      return m_ptr ? 2 : 1;
`else
      return 1;
`endif
    end
    if (f_req_i) return 1;
    if (d_req_i) return 2;
    return 0;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid <= 1'b0;
      m_ptr   <= 1'b0;
    end else if (winner() != 0) begin
      m_valid <= 1'b1;
      m_owner <= (winner() == 2);
      m_addr  <= (winner() == 2) ? d_addr_i : f_addr_i;
      m_err   <= bad_addr((winner() == 2) ? d_addr_i : f_addr_i);
      if (f_req_i && d_req_i) m_ptr <= !m_ptr;
    end else if (m_valid && (m_owner ? d_rready_i : f_rready_i)) begin
      m_valid <= 1'b0;
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = {16'h0, 14'($urandom_range(0, MEMW - 1)), 2'($urandom_range(1, 3))};
      1: a = {16'($urandom_range(1, 65535)), 14'($urandom_range(0, MEMW - 1)), 2'b00};
      default: a = {16'h0, 14'($urandom_range(0, MEMW - 1)), 2'b00};
    endcase
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; f_req_i = 1'b0; d_req_i = 1'b0; f_rready_i = 1'b1; d_rready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; f_req_i = 1'b1; d_req_i = 1'b1; f_addr_i = 32'h10; d_addr_i = 32'h20;
    #1;
    n_checks++; if ({f_gnt_o, d_gnt_o, mem_rden_o} !== 3'b000) begin n_errors++; $display("FAIL reset_gnt_rden got=%b exp=000", {f_gnt_o, d_gnt_o, mem_rden_o}); end
    n_checks++; if ({f_rvalid_o, f_err_o, d_rvalid_o, d_err_o} !== 4'b0000) begin n_errors++; $display("FAIL reset_rsp got=%b exp=0000", {f_rvalid_o, f_err_o, d_rvalid_o, d_err_o}); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
    n_checks++; if ({f_rdata_o, d_rdata_o} !== 64'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", {f_rdata_o, d_rdata_o}); end
    @(negedge clk_i);
    rst_ni = 1'b1; f_req_i = 1'b0; d_req_i = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk_i);
    f_req_i = 1'b1; f_addr_i = 32'h10; f_rready_i = 1'b1; d_req_i = 1'b0;
    #1;
    n_checks++; if ({f_gnt_o, d_gnt_o, mem_rden_o} !== 3'b101) begin n_errors++; $display("FAIL fetch_gnt got=%b exp=101", {f_gnt_o, d_gnt_o, mem_rden_o}); end
    n_checks++; if (mem_addr_o !== 32'h10) begin n_errors++; $display("FAIL fetch_mem_addr got=%h exp=10", mem_addr_o); end
    @(negedge clk_i);
    f_req_i = 1'b0;
    #1;
    n_checks++; if ({f_rvalid_o, f_err_o, d_rvalid_o} !== 3'b100) begin n_errors++; $display("FAIL fetch_rvalid got=%b exp=100", {f_rvalid_o, f_err_o, d_rvalid_o}); end
    n_checks++; if (f_rdata_o !== mem[4]) begin n_errors++; $display("FAIL fetch_rdata got=%h exp=%h", f_rdata_o, mem[4]); end
  endtask

  task automatic test_contention();
    logic exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      f_req_i = 1'b1; d_req_i = 1'b1; f_addr_i = 32'h40 + 32'(4 * i); d_addr_i = 32'h80 + 32'(4 * i);
      #1;
`ifdef IMEM_ARB_RR_EN
      exp_d = (i % 2) == 1;
`else
      exp_d = 1'b0;
`endif
      n_checks++; if ({f_gnt_o, d_gnt_o} !== {!exp_d, exp_d}) begin n_errors++; $display("FAIL contention_gnt cyc=%0d got=%b exp=%b", i, {f_gnt_o, d_gnt_o}, {!exp_d, exp_d}); end
    end
    @(negedge clk_i);
    f_req_i = 1'b0; d_req_i = 1'b0;
  endtask

  task automatic test_errors();
    @(negedge clk_i);
    d_req_i = 1'b1; d_addr_i = 32'h3; d_rready_i = 1'b1; f_req_i = 1'b0;
    #1;
    n_checks++; if ({d_gnt_o, mem_rden_o, mem_addr_o} !== {2'b10, 32'h0}) begin n_errors++; $display("FAIL err_misaligned_gnt got=%b/%h exp=10/0", {d_gnt_o, mem_rden_o}, mem_addr_o); end
    @(negedge clk_i);
    d_addr_i = 32'h0001_0000;
    #1;
    n_checks++; if ({d_gnt_o, mem_rden_o} !== 2'b10) begin n_errors++; $display("FAIL err_range_gnt got=%b exp=10", {d_gnt_o, mem_rden_o}); end
    n_checks++; if ({d_rvalid_o, d_err_o, f_rvalid_o, d_rdata_o} !== {3'b110, 32'h0}) begin n_errors++; $display("FAIL err_misaligned_rsp got=%b/%h exp=110/0", {d_rvalid_o, d_err_o, f_rvalid_o}, d_rdata_o); end
    @(negedge clk_i);
    d_req_i = 1'b0;
    #1;
    n_checks++; if ({d_rvalid_o, d_err_o, d_rdata_o} !== {2'b11, 32'h0}) begin n_errors++; $display("FAIL err_range_rsp got=%b/%h exp=11/0", {d_rvalid_o, d_err_o}, d_rdata_o); end
    @(negedge clk_i);
    #1;
    n_checks++; if (d_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL err_drain got=%b exp=0", d_rvalid_o); end
  endtask

  task automatic test_stall();
    @(negedge clk_i);
    f_req_i = 1'b1; f_addr_i = 32'h20; f_rready_i = 1'b0; d_req_i = 1'b0;
    #1;
    n_checks++; if (f_gnt_o !== 1'b1) begin n_errors++; $display("FAIL stall_first_gnt got=%b exp=1", f_gnt_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      f_addr_i = 32'h24; d_req_i = 1'b1; d_addr_i = 32'h30; d_rready_i = 1'b1;
      #1;
      n_checks++; if ({f_rvalid_o, f_gnt_o, d_gnt_o, mem_rden_o} !== 4'b1000) begin n_errors++; $display("FAIL stall_hold cyc=%0d got=%b exp=1000", i, {f_rvalid_o, f_gnt_o, d_gnt_o, mem_rden_o}); end
      n_checks++; if (f_rdata_o !== mem[8]) begin n_errors++; $display("FAIL stall_rdata cyc=%0d got=%h exp=%h", i, f_rdata_o, mem[8]); end
    end
    @(negedge clk_i);
    f_rready_i = 1'b1;
    #1;
    n_checks++; if ({f_rvalid_o, f_gnt_o, mem_rden_o, mem_addr_o} !== {3'b111, 32'h24}) begin n_errors++; $display("FAIL stall_release got=%b/%h exp=111/24", {f_rvalid_o, f_gnt_o, mem_rden_o}, mem_addr_o); end
    n_checks++; if (f_rdata_o !== mem[8]) begin n_errors++; $display("FAIL stall_release_rdata got=%h exp=%h", f_rdata_o, mem[8]); end
    @(negedge clk_i);
    f_req_i = 1'b0; d_req_i = 1'b0;
    #1;
    n_checks++; if ({f_rvalid_o, f_rdata_o} !== {1'b1, mem[9]}) begin n_errors++; $display("FAIL stall_next_rsp got=%b/%h exp=1/%h", f_rvalid_o, f_rdata_o, mem[9]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    f_req_i = 1'b1; f_addr_i = 32'h44; f_rready_i = 1'b0; d_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_checks++; if ({f_gnt_o, f_rvalid_o, f_err_o, mem_rden_o} !== 4'b0000) begin n_errors++; $display("FAIL rstmid_outputs got=%b exp=0000", {f_gnt_o, f_rvalid_o, f_err_o, mem_rden_o}); end
    n_checks++; if ({f_rdata_o, mem_addr_o} !== 64'h0) begin n_errors++; $display("FAIL rstmid_data got=%h exp=0", {f_rdata_o, mem_addr_o}); end
    @(negedge clk_i);
    rst_ni = 1'b1; f_req_i = 1'b0; f_rready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if ({f_rvalid_o, d_rvalid_o} !== 2'b00) begin n_errors++; $display("FAIL rstmid_no_rsp cyc=%0d got=%b exp=00", i, {f_rvalid_o, d_rvalid_o}); end
      @(negedge clk_i);
    end
    f_req_i = 1'b1; f_addr_i = 32'h48;
    #1;
    n_checks++; if (f_gnt_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_regrant got=%b exp=1", f_gnt_o); end
    @(negedge clk_i);
    f_req_i = 1'b0;
    #1;
    n_checks++; if ({f_rvalid_o, f_rdata_o} !== {1'b1, mem[18]}) begin n_errors++; $display("FAIL rstmid_rsp got=%b/%h exp=1/%h", f_rvalid_o, f_rdata_o, mem[18]); end
  endtask

  task automatic test_random();
    int w;
    logic [31:0] ga;
    logic erden, fv, dv;
    logic [102:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      rst_ni     = ($urandom_range(0, 99) != 0);
      f_req_i    = ($urandom_range(0, 2) != 0);
      d_req_i    = ($urandom_range(0, 2) != 0);
      f_addr_i   = rand_addr();
      d_addr_i   = rand_addr();
      f_rready_i = ($urandom_range(0, 3) != 0);
      d_rready_i = ($urandom_range(0, 3) != 0);
      #1;
      w     = winner();
      ga    = (w == 2) ? d_addr_i : f_addr_i;
      erden = (w != 0) && !bad_addr(ga);
      fv    = m_valid && !m_owner;
      dv    = m_valid && m_owner;
      exp = {w == 1, w == 2, erden, erden ? ga : 32'h0,
             fv, (fv && !m_err) ? mem[m_addr[AW-1:2]] : 32'h0, fv && m_err,
             dv, (dv && !m_err) ? mem[m_addr[AW-1:2]] : 32'h0, dv && m_err};
      got = {f_gnt_o, d_gnt_o, mem_rden_o, mem_addr_o, f_rvalid_o, f_rdata_o, f_err_o,
             d_rvalid_o, d_rdata_o, d_err_o};
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, got, exp); end
    end
    @(negedge clk_i);
    rst_ni = 1'b1; f_req_i = 1'b0; d_req_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    test_reset();
    test_single_fetch();
    test_contention();
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
